// File: rtl/booth_seq_mul.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, start/busy/done handshake.
// Handles signed and unsigned WIDTH x WIDTH operands exactly via a (WIDTH+1)-bit extension and a guard bit.
module booth_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p_out
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [WIDTH+1:0]   acc;
    logic [WIDTH:0]     q_reg;
    logic [WIDTH:0]     m_reg;
    logic               q_1;
    logic [CW-1:0]      cnt;

    logic               load;
    logic               last;
    logic [WIDTH+1:0]   m_ext;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH+2:0] shifted;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // One Booth step: add/subtract the multiplicand, then arithmetic-shift {acc, q_reg, q_1}.
    always_comb begin
        m_ext = {m_reg[WIDTH], m_reg};
        case ({q_reg[0], q_1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
        shifted = {sum[WIDTH+1], sum, q_reg[WIDTH:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            q_reg <= '0;
            m_reg <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            p_out <= '0;
        end else begin
            done <= last;
            if (load) begin
                acc   <= '0;
                q_reg <= {signed_mode & a_in[WIDTH-1], a_in};
                m_reg <= {signed_mode & b_in[WIDTH-1], b_in};
                q_1   <= 1'b0;
                cnt   <= CW'(WIDTH + 1);
            end else if (busy) begin
                acc   <= shifted[2*WIDTH+2:WIDTH+1];
                q_reg <= shifted[WIDTH:0];
                q_1   <= q_reg[0];
                cnt   <= cnt - CW'(1);
                if (last) p_out <= shifted[2*WIDTH-1:0];
            end
        end
    end

endmodule
